// File: rtl/reg_drp_multi.sv
// Register-bus bridge to the DRP ports of up to eight MMCM/PLL primitives, with launch FSM, status and hang timeout.
// Define DRP_RMW_EN to add the mask register and hardware read-modify-write.
module reg_drp_multi #(
  parameter int unsigned pBYTECNT_SIZE = 7,
  parameter int unsigned pCHANNELS     = 2,
  parameter int unsigned pTIMEOUT      = 255,
  parameter int unsigned pDRP_ADDR     = 0,
  parameter int unsigned pDRP_DATA     = 1,
  parameter int unsigned pDRP_CHAN     = 2,
  parameter int unsigned pDRP_STATUS   = 3,
  parameter int unsigned pDRP_MASK     = 4
) (
  input  logic                       clk_usb,
  input  logic                       reset_n,
  input  logic [7:0]                 reg_address,
  input  logic [pBYTECNT_SIZE-1:0]   reg_bytecnt,
  input  logic [7:0]                 reg_datai,
  output logic [7:0]                 reg_datao,
  input  logic                       reg_read,
  input  logic                       reg_write,
  output logic [6:0]                 drp_addr,
  output logic [15:0]                drp_din,
  output logic [pCHANNELS-1:0]       drp_den,
  output logic                       drp_dwe,
  input  logic [16*pCHANNELS-1:0]    drp_dout,
  input  logic [pCHANNELS-1:0]       drp_drdy
);

  localparam int unsigned LP_CNT_W = 16;
  localparam logic [7:0] LP_A_ADDR   = 8'(pDRP_ADDR);
  localparam logic [7:0] LP_A_DATA   = 8'(pDRP_DATA);
  localparam logic [7:0] LP_A_CHAN   = 8'(pDRP_CHAN);
  localparam logic [7:0] LP_A_STATUS = 8'(pDRP_STATUS);
  localparam logic [LP_CNT_W-1:0] LP_TO_LAST = LP_CNT_W'(pTIMEOUT - 1);
  localparam logic [pBYTECNT_SIZE-1:0] LP_BC0 = '0;
  localparam logic [pBYTECNT_SIZE-1:0] LP_BC1 = pBYTECNT_SIZE'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t                r_state;
  logic [7:0]            r_datao;
  logic [6:0]            r_drp_addr;
  logic [15:0]           r_din;
  logic [pCHANNELS-1:0]  r_den;
  logic                  r_dwe;
  logic [15:0]           r_wdata;
  logic [15:0]           r_rdata;
  logic [2:0]            r_chan;
  logic [2:0]            r_cur_chan;
  logic                  r_op_wr;
  logic                  r_phase_wr;
  logic [LP_CNT_W-1:0]   r_cnt;
  logic                  r_done;
  logic                  r_timeout;
  logic                  r_overrun;
  logic                  r_badchan;
`ifdef DRP_RMW_EN
  localparam logic [7:0] LP_A_MASK = 8'(pDRP_MASK);
  logic [15:0]           r_mask;
  logic                  r_rmw;
`endif

  logic                  w_bc0;
  logic                  w_bc1;
  logic                  w_launch;
  logic                  w_busy;
  logic                  w_chan_ok;
  logic                  w_rmw_start;
  logic [7:0]            w_oh8;
  logic [7:0]            w_cur_oh8;
  logic [7:0]            w_drdy8;
  logic                  w_drdy_sel;
  logic [15:0]           w_dout_arr [8];
  logic [15:0]           w_dout_sel;
  logic [7:0]            w_rd_mux;

  // Zero-pad the per-channel DRP inputs to eight entries so channel muxing is width-independent
  for (genvar c = 0; c < 8; c++) begin : g_pad
    if (c < pCHANNELS) begin : g_on
      assign w_dout_arr[c] = drp_dout[16*c +: 16];
    end else begin : g_off
      assign w_dout_arr[c] = 16'h0000;
    end
  end

  assign w_drdy8    = 8'(drp_drdy);
  assign w_drdy_sel = w_drdy8[r_cur_chan];
  assign w_dout_sel = w_dout_arr[r_cur_chan];
  assign w_oh8      = 8'(1) << r_chan;
  assign w_cur_oh8  = 8'(1) << r_cur_chan;

  assign w_bc0     = (reg_bytecnt == LP_BC0);
  assign w_bc1     = (reg_bytecnt == LP_BC1);
  assign w_launch  = reg_write && (reg_address == LP_A_ADDR) && w_bc0;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_chan_ok = ({1'b0, r_chan} < 4'(pCHANNELS));

`ifdef DRP_RMW_EN
  assign w_rmw_start = reg_datai[7] && (r_mask != 16'h0000);
`else
  assign w_rmw_start = 1'b0;
`endif

  // Register read mux; sampled into reg_datao only while reg_read is high
  always_comb begin
    w_rd_mux = 8'h00;
    if (reg_address == LP_A_ADDR) begin
      w_rd_mux = {r_op_wr, r_drp_addr};
    end else if (reg_address == LP_A_DATA) begin
      if (w_bc0)      w_rd_mux = r_rdata[7:0];
      else if (w_bc1) w_rd_mux = r_rdata[15:8];
    end else if (reg_address == LP_A_CHAN) begin
      w_rd_mux = {5'b00000, r_chan};
    end else if (reg_address == LP_A_STATUS) begin
      w_rd_mux = {3'b000, r_badchan, r_overrun, r_timeout, r_done, w_busy};
`ifdef DRP_RMW_EN
    end else if (reg_address == LP_A_MASK) begin
      if (w_bc0)      w_rd_mux = r_mask[7:0];
      else if (w_bc1) w_rd_mux = r_mask[15:8];
`endif
    end
  end

  always_ff @(posedge clk_usb) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_datao    <= 8'h00;
      r_drp_addr <= 7'h00;
      r_din      <= 16'h0000;
      r_den      <= '0;
      r_dwe      <= 1'b0;
      r_wdata    <= 16'h0000;
      r_rdata    <= 16'h0000;
      r_chan     <= 3'd0;
      r_cur_chan <= 3'd0;
      r_op_wr    <= 1'b0;
      r_phase_wr <= 1'b0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_overrun  <= 1'b0;
      r_badchan  <= 1'b0;
`ifdef DRP_RMW_EN
      r_mask     <= 16'h0000;
      r_rmw      <= 1'b0;
`endif
    end else begin
      r_datao <= reg_read ? w_rd_mux : 8'h00;
      r_den   <= '0;
      r_dwe   <= 1'b0;

      // Status clear comes first so FSM events in the same cycle still register
      if (reg_write && (reg_address == LP_A_STATUS)) begin
        r_done    <= 1'b0;
        r_timeout <= 1'b0;
        r_overrun <= 1'b0;
        r_badchan <= 1'b0;
      end
      if (reg_write && (reg_address == LP_A_DATA)) begin
        if (w_bc0)      r_wdata[7:0]  <= reg_datai;
        else if (w_bc1) r_wdata[15:8] <= reg_datai;
      end
`ifdef DRP_RMW_EN
      if (reg_write && (reg_address == LP_A_MASK)) begin
        if (w_bc0)      r_mask[7:0]  <= reg_datai;
        else if (w_bc1) r_mask[15:8] <= reg_datai;
      end
`endif
      if (reg_write && (reg_address == LP_A_CHAN) && w_bc0) begin
        r_chan <= reg_datai[2:0];
      end

      if (w_launch) begin
        if (w_busy) begin
          r_overrun <= 1'b1;
        end else if (!w_chan_ok) begin
          r_badchan <= 1'b1;
        end else begin
          r_done     <= 1'b0;
          r_timeout  <= 1'b0;
          r_badchan  <= 1'b0;
          r_drp_addr <= reg_datai[6:0];
          r_op_wr    <= reg_datai[7];
          r_cur_chan <= r_chan;
          r_den      <= w_oh8[pCHANNELS-1:0];
          r_dwe      <= reg_datai[7] && !w_rmw_start;
          r_phase_wr <= reg_datai[7] && !w_rmw_start;
          r_din      <= r_wdata;
`ifdef DRP_RMW_EN
          r_rmw      <= w_rmw_start;
`endif
          r_state    <= ST_REQ;
        end
      end

      case (r_state)
        ST_REQ: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_drdy_sel) begin
            if (!r_phase_wr) r_rdata <= w_dout_sel;
`ifdef DRP_RMW_EN
            // Read phase of RMW: merge fresh read data and issue the write phase
            if (r_rmw && !r_phase_wr) begin
              r_den      <= w_cur_oh8[pCHANNELS-1:0];
              r_dwe      <= 1'b1;
              r_phase_wr <= 1'b1;
              r_din      <= (w_dout_sel & ~r_mask) | (r_wdata & r_mask);
              r_state    <= ST_REQ;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
`else
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
`endif
          end else if (r_cnt == LP_TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + LP_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_datao = r_datao;
  assign drp_addr  = r_drp_addr;
  assign drp_din   = r_din;
  assign drp_den   = r_den;
  assign drp_dwe   = r_dwe;

endmodule
